// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a shared single-port datapath.
// Moore outputs from the state and class registers; memory waits are bounded by MEM_TIMEOUT.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic [2:0] imm_control,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_OPIMM, C_LOAD, C_JALR, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL
  } cls_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  state_t        state_q;
  cls_t          cls_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    cause_q;
  logic          mem_phase;
  logic          timeout_hit;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: classify = C_R;
      7'b0010011: classify = C_OPIMM;
      7'b0000011: classify = C_LOAD;
      7'b1100111: classify = C_JALR;
      7'b0100011: classify = C_STORE;
      7'b1100011: classify = C_BRANCH;
      7'b0110111: classify = C_LUI;
      7'b0010111: classify = C_AUIPC;
      7'b1101111: classify = C_JAL;
      default:    classify = C_NONE;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input cls_t c);
    case (c)
      C_OPIMM, C_LOAD, C_JALR: imm_of = 3'b001;
      C_STORE:                 imm_of = 3'b010;
      C_BRANCH:                imm_of = 3'b011;
      C_LUI, C_AUIPC:          imm_of = 3'b100;
      C_JAL:                   imm_of = 3'b101;
      default:                 imm_of = 3'b000;
    endcase
  endfunction

  assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEM);
  // A ready on the limit cycle completes the handshake instead of trapping.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_phase && !mem_ready && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      if ((MEM_TIMEOUT != 0) && mem_phase && !mem_ready && !timeout_hit)
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;

      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            cause_q <= 2'b10;
          end
        end
        S_DECODE: begin
          cls_q <= classify(opcode);
          if (classify(opcode) == C_NONE) begin
            state_q <= S_TRAP;
            cause_q <= 2'b01;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_BRANCH:       state_q <= S_FETCH;
            C_LOAD, C_STORE: state_q <= S_MEM;
            default:        state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            cause_q <= 2'b10;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Everything is forced low while reset is asserted, even though state_q reads FETCH.
  always_comb begin
    imm_control   = 3'b000;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    instr_retired = 1'b0;
    trap          = 1'b0;
    trap_cause    = 2'b00;
    state         = 3'b000;
    if (rst_n) begin
      state      = state_q;
      trap_cause = cause_q;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: imm_control = imm_of(classify(opcode));
        S_EXEC: begin
          imm_control = imm_of(cls_q);
          case (cls_q)
            C_OPIMM, C_LOAD, C_STORE, C_JALR: alu_src_b = 2'b01;
            C_AUIPC, C_JAL: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b01;
            end
            C_BRANCH: begin
              pc_write      = branch_taken;
              pc_src        = 2'b10;
              instr_retired = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          imm_control   = imm_of(cls_q);
          mem_req       = 1'b1;
          mem_addr_sel  = 1'b1;
          mem_we        = (cls_q == C_STORE);
          instr_retired = (cls_q == C_STORE) && mem_ready;
        end
        S_WB: begin
          imm_control   = imm_of(cls_q);
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          case (cls_q)
            C_LOAD: wb_sel = 2'b01;
            C_JAL: begin
              wb_sel   = 2'b10;
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            C_JALR: begin
              wb_sel   = 2'b10;
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            C_LUI:   wb_sel = 2'b11;
            default: wb_sel = 2'b00;
          endcase
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a phase-level instruction model predicts every output each cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic [2:0] imm_control;
  logic       ir_write, pc_write, mem_req, mem_we, mem_addr_sel, alu_src_a;
  logic [1:0] pc_src, alu_src_b, wb_sel, trap_cause;
  logic       reg_write, instr_retired, trap;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .imm_control(imm_control), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  typedef enum int {K_NONE, K_R, K_OPIMM, K_LOAD, K_JALR, K_STORE, K_BRANCH, K_LUI, K_AUIPC, K_JAL} kind_t;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 7;
  localparam int TIMEOUT = 16;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h13};
  logic [31:0] dir_ops[$] = '{32'h07B00013, 32'h140020A3, 32'h00000263, 32'h00000263,
                              32'h0A455037, 32'hFE9FF0EF, 32'h00000000};
  int dir_waits[$] = '{0, 0, 3, 0, 0, 0, 0, 0, 16};

  int         ph, wcnt, wtgt, cause, trap_cyc, trap_hold;
  kind_t      kind;
  logic [6:0] cur_op;
  logic       did_mid_load;

  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      7'h33: return K_R;
      7'h13: return K_OPIMM;
      7'h03: return K_LOAD;
      7'h67: return K_JALR;
      7'h23: return K_STORE;
      7'h63: return K_BRANCH;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6f: return K_JAL;
      default: return K_NONE;
    endcase
  endfunction

  function automatic logic [2:0] imm_tbl(input kind_t k);
    case (k)
      K_OPIMM, K_LOAD, K_JALR: return 3'd1;
      K_STORE:                 return 3'd2;
      K_BRANCH:                return 3'd3;
      K_LUI, K_AUIPC:          return 3'd4;
      K_JAL:                   return 3'd5;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic int draw_wait();
    int r;
    if (dir_waits.size() > 0) return dir_waits.pop_front();
    r = $urandom_range(0, 99);
    if (r < 55) return 0;
    if (r < 85) return $urandom_range(1, 3);
    if (r < 93) return TIMEOUT - 1;
    if (r < 96) return TIMEOUT;
    return 0;
  endfunction

  function automatic logic [6:0] draw_op();
    logic [31:0] w;
    if (dir_ops.size() > 0) begin
      w = dir_ops.pop_front();
      return w[6:0];
    end
    if ($urandom_range(0, 19) == 0) return 7'($urandom);
    return legal_ops[$urandom_range(0, 9)];
  endfunction

  task automatic enter_fetch();
    ph = P_FETCH; wcnt = 0; wtgt = draw_wait(); cur_op = draw_op();
  endtask

  task automatic enter_mem();
    ph = P_MEM; wcnt = 0; wtgt = draw_wait();
  endtask

  task automatic drive();
    opcode       = cur_op;
    branch_taken = 1'($urandom_range(0, 1));
    if (ph == P_FETCH || ph == P_MEM) mem_ready = (wcnt == wtgt);
    else                              mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_outputs();
    logic [2:0] e_imm;
    logic [3:0] e_pc;
    logic [2:0] e_mem;
    logic [2:0] e_alu;
    logic [3:0] e_wb;
    logic [2:0] e_trap;
    e_imm = 0; e_pc = 0; e_mem = 0; e_alu = 0; e_wb = 0; e_trap = 0;
    case (ph)
      P_FETCH: begin
        e_mem = 3'b100;
        if (mem_ready) e_pc = 4'b1100;
      end
      P_DECODE: e_imm = imm_tbl(kind_of(opcode));
      P_EXEC: begin
        e_imm = imm_tbl(kind);
        if (kind inside {K_OPIMM, K_LOAD, K_STORE, K_JALR}) e_alu = 3'b001;
        if (kind inside {K_AUIPC, K_JAL})                   e_alu = 3'b101;
        if (kind == K_BRANCH) begin
          e_pc = {1'b0, branch_taken, 2'b10};
          e_wb = 4'b0001;
        end
      end
      P_MEM: begin
        e_imm = imm_tbl(kind);
        e_mem = {1'b1, kind == K_STORE, 1'b1};
        e_wb  = {3'b000, (kind == K_STORE) && mem_ready};
      end
      P_WB: begin
        e_imm = imm_tbl(kind);
        case (kind)
          K_LOAD:  e_wb = 4'b1011;
          K_JAL:   begin e_wb = 4'b1101; e_pc = 4'b0110; end
          K_JALR:  begin e_wb = 4'b1101; e_pc = 4'b0101; end
          K_LUI:   e_wb = 4'b1111;
          default: e_wb = 4'b1001;
        endcase
      end
      P_TRAP: e_trap = {1'b1, 2'(cause)};
      default: ;
    endcase
    chk("state", state, ph);
    chk("imm_control", imm_control, e_imm);
    chk("ir/pc", {ir_write, pc_write, pc_src}, e_pc);
    chk("mem", {mem_req, mem_we, mem_addr_sel}, e_mem);
    chk("alu_src", {alu_src_a, alu_src_b}, e_alu);
    chk("wb/retire", {reg_write, wb_sel, instr_retired}, e_wb);
    chk("trap", {trap, trap_cause}, e_trap);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {imm_control, ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_src_a,
              alu_src_b, reg_write, wb_sel, instr_retired, trap, trap_cause, state}, 32'd0);
  endtask

  task automatic advance();
    case (ph)
      P_FETCH: begin
        if (mem_ready) ph = P_DECODE;
        else begin
          wcnt++;
          if (wcnt == TIMEOUT) begin ph = P_TRAP; cause = 2; end
        end
      end
      P_DECODE: begin
        kind = kind_of(opcode);
        if (kind == K_NONE) begin ph = P_TRAP; cause = 1; end
        else ph = P_EXEC;
      end
      P_EXEC: begin
        if (kind == K_BRANCH) enter_fetch();
        else if (kind == K_LOAD || kind == K_STORE) enter_mem();
        else ph = P_WB;
      end
      P_MEM: begin
        if (mem_ready) begin
          if (kind == K_LOAD) ph = P_WB;
          else enter_fetch();
        end else begin
          wcnt++;
          if (wcnt == TIMEOUT) begin ph = P_TRAP; cause = 2; end
        end
      end
      P_WB:    enter_fetch();
      default: trap_cyc++;
    endcase
  endtask

  // Reset is asserted mid-cycle so the check catches outputs that only clear on a clock edge.
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1 check_all_zero(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cause = 0; kind = K_NONE; trap_cyc = 0; trap_hold = $urandom_range(3, 8);
    enter_fetch();
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    cause = 0; kind = K_NONE; trap_cyc = 0; trap_hold = 20; did_mid_load = 1'b0;
    ph = P_FETCH; wcnt = 0; wtgt = 0; cur_op = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_hold");
    mem_ready = 1'b1;
    #1 check_all_zero("reset_ready");
    @(posedge clk);
    #1 rst_n = 1'b1;
    enter_fetch();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive();
      @(negedge clk);
      check_outputs();
      if (ph == P_TRAP && trap_cyc >= trap_hold) begin
        reset_pulse("trap_reset");
      end else if (ph == P_MEM && kind == K_LOAD && !did_mid_load) begin
        did_mid_load = 1'b1;
        reset_pulse("mid_load_reset");
      end else if ($urandom_range(0, 249) == 0) begin
        reset_pulse("random_reset");
      end else begin
        @(posedge clk);
        advance();
        #1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the shared datapath (register file, ALU, immediate decoder, unified memory port) through FETCH/DECODE/EXEC/MEM/WB.
Classifies the latched opcode and drives imm_control for the immediate decoder.
Generates all per-state datapath enables and a req/ready memory handshake with timeout.
Illegal opcodes and memory stalls trap.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before trap; 0 disables timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  inst[6:0] from instruction register, valid from DECODE onward
branch_taken  input  1  datapath branch compare result, sampled in EXEC
mem_ready  input  1  memory completes current request this cycle
imm_control  output  3  000 none/R, 001 I, 010 S, 011 B, 100 U, 101 J
ir_write  output  1  load instruction register and old_pc
pc_write  output  1  update PC
pc_src  output  2  00 PC+4, 01 ALU result, 10 old_pc+imm
mem_req  output  1  memory request
mem_we  output  1  store request
mem_addr_sel  output  1  0 PC, 1 ALU result
alu_src_a  output  1  0 rs1, 1 old_pc
alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4
reg_write  output  1  register file write enable
wb_sel  output  2  00 ALU, 01 mem data, 10 old_pc+4, 11 imm
instr_retired  output  1  one-cycle pulse, instruction completed
trap  output  1  controller halted in TRAP
trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout
state  output  3  FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, TRAP 111

Behaviour:
- Reset (rst_n low, any state, including mid-handshake): state=FETCH, class=NONE, timeout counter=0, trap_cause=00. All outputs 0 while rst_n low. First request issues in the first cycle after release.
- Outputs are combinational from the state register and the class register (Moore). imm_control is derived from class and holds from DECODE until return to FETCH. It is 000 in FETCH.
- Opcode classes, latched on the DECODE edge:
  - 0110011 R: imm 000
  - 0010011 OPIMM / 0000011 LOAD / 1100111 JALR: imm 001
  - 0100011 STORE: imm 010
  - 1100011 BRANCH: imm 011
  - 0110111 LUI / 0010111 AUIPC: imm 100
  - 1101111 JAL: imm 101
  - Any other opcode: DECODE→TRAP, trap_cause=01.
- FETCH: mem_req=1, mem_addr_sel=0. While mem_ready is high: ir_write=1, pc_write=1, pc_src=00, and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: no enables asserted; one cycle.
- EXEC:
  - R: src_b=00.
  - OPIMM/LOAD/STORE/JALR: src_b=01.
  - AUIPC/JAL: src_a=1, src_b=01.
  - BRANCH: src_b=00; pc_write=branch_taken, pc_src=10.
  - Next state: BRANCH→FETCH with instr_retired=1; LOAD/STORE→MEM; all others→WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. Holds until mem_ready. Then LOAD→WB; STORE→FETCH with instr_retired=1.
- WB: reg_write=1.
  - wb_sel: R/OPIMM/AUIPC 00, LOAD 01, JAL/JALR 10, LUI 11.
  - JAL: also pc_write=1, pc_src=10.
  - JALR: also pc_write=1, pc_src=01; ALU output held by the datapath ALU-out register.
  - instr_retired=1 on the WB cycle; next state is FETCH.
- Timeout: the counter increments each cycle mem_req=1 and mem_ready=0. It clears on a handshake or a state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with no ready: next state TRAP, trap_cause=10.
  - mem_ready arriving on the same cycle the limit is hit wins: the handshake completes and there is no trap.
- TRAP: all enables 0, trap=1, trap_cause held. Exit only via reset.
- mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory, in cycles:
  - R/OPIMM/LUI/AUIPC/JAL/JALR: 4.
  - BRANCH: 3.
  - STORE: 4.
  - LOAD: 5.

Test Plan:
- addi 0x07B00013, mem_ready tied 1 → states 000,001,010,100,000. imm_control=001 from DECODE. EXEC src_b=01. WB reg_write=1, wb_sel=00. instr_retired pulse at cycle 4.
- sw 0x140020A3, mem_ready delayed 3 cycles in MEM → imm_control=010. MEM holds mem_req=1, mem_we=1, addr_sel=1 for 4 cycles. Then FETCH; reg_write never asserted.
- beq 0x00000263 with branch_taken=1, then repeated with 0 → imm_control=011. EXEC pc_write=1, pc_src=10 in the first run, pc_write=0 in the second. Back in FETCH after 3 cycles.
- lui 0x0A455037 then jal 0xFE9FF0EF:
  - lui → imm 100, WB wb_sel=11.
  - jal → imm 101. EXEC src_a=1. WB reg_write=1, wb_sel=10, pc_write=1, pc_src=10.
- Opcode 0000000 fetched → TRAP at cycle 3, trap=1, trap_cause=01. Holds 20 cycles. rst_n pulse returns to FETCH with trap_cause=00.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=16 → TRAP after 16 waiting cycles, trap_cause=10.
- Separately, rst_n asserted mid-MEM of a load → all outputs 0 immediately (asynchronous); restarts in FETCH.
